// File: rtl/ramp_gen_pkg.sv
// Shared definitions for the ramp generator: mode encodings on the mode input.
// Used by ramp_gen and its bench.
package ramp_gen_pkg;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DN   = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage

// File: rtl/ramp_gen_tick.sv
// Prescaler for ramp_gen: one tick every DIV enabled cycles.
// The count freezes while disabled, so a paused period resumes where it stopped.
module ramp_gen_tick #(
    parameter int DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = i_en && w_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ramp_gen.sv
// Sawtooth/triangle ramp generator bounded by [lo,hi], stepping on a prescaled tick.
// Triangle mode is built only when RAMP_GEN_TRIANGLE_EN is defined; otherwise mode 10 is saw-up.
module ramp_gen
    import ramp_gen_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    output logic [WIDTH-1:0] o_ramp,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_ramp;
    logic             r_wrap;
    logic             w_tick;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_floor;
    logic             w_over;
    logic             w_below;
    logic             w_bad_lim;
    logic             w_out;
    logic             w_freeze;
    logic             w_mode_dn;
    logic [WIDTH-1:0] w_nxt_ramp;
    logic             w_nxt_wrap;

    ramp_gen_tick #(.DIV(DIV)) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .o_tick (w_tick)
    );

    // Compares are one bit wider so a large step can never wrap silently.
    assign w_sum     = {1'b0, r_ramp} + {1'b0, i_step};
    assign w_floor   = {1'b0, i_lo} + {1'b0, i_step};
    assign w_over    = w_sum > {1'b0, i_hi};
    assign w_below   = {1'b0, r_ramp} < w_floor;
    assign w_bad_lim = i_lo > i_hi;
    assign w_out     = (r_ramp < i_lo) || (r_ramp > i_hi);
    assign w_freeze  = (i_mode == MODE_HOLD) || (i_step == '0);
    assign w_mode_dn = (i_mode == MODE_DN);

`ifdef RAMP_GEN_TRIANGLE_EN
    logic r_dn;
    logic r_tri_act;
    logic w_tri;
    logic w_dn;
    logic w_nxt_dn;

    assign w_tri = (i_mode == MODE_TRI);
    // A stale direction is ignored unless the previous tick was also triangle.
    assign w_dn  = r_dn && r_tri_act;
`endif

    always_comb begin
        w_nxt_ramp = r_ramp;
        w_nxt_wrap = 1'b0;
`ifdef RAMP_GEN_TRIANGLE_EN
        w_nxt_dn   = w_dn;
`endif
        if (w_bad_lim) begin
            w_nxt_ramp = i_lo;
        end else if (!w_freeze) begin
            if (w_out) begin
                w_nxt_ramp = w_mode_dn ? i_hi : i_lo;
`ifdef RAMP_GEN_TRIANGLE_EN
                w_nxt_dn   = 1'b0;
`endif
            end else if (w_mode_dn) begin
                if (w_below) begin
                    w_nxt_ramp = i_hi;
                    w_nxt_wrap = 1'b1;
                end else begin
                    w_nxt_ramp = r_ramp - i_step;
                end
`ifdef RAMP_GEN_TRIANGLE_EN
            end else if (w_tri && w_dn) begin
                if (w_below) begin
                    w_nxt_ramp = i_lo;
                    w_nxt_wrap = 1'b1;
                    w_nxt_dn   = 1'b0;
                end else begin
                    w_nxt_ramp = r_ramp - i_step;
                end
            end else if (w_tri) begin
                if (w_over) begin
                    w_nxt_ramp = i_hi;
                    w_nxt_dn   = 1'b1;
                end else begin
                    w_nxt_ramp = w_sum[WIDTH-1:0];
                end
`endif
            end else begin
                if (w_over) begin
                    w_nxt_ramp = i_lo;
                    w_nxt_wrap = 1'b1;
                end else begin
                    w_nxt_ramp = w_sum[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ramp <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_tick) begin
                r_ramp <= w_nxt_ramp;
                r_wrap <= w_nxt_wrap;
            end
        end
    end

`ifdef RAMP_GEN_TRIANGLE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dn      <= 1'b0;
            r_tri_act <= 1'b0;
        end else if (w_tick) begin
            r_dn      <= w_nxt_dn;
            r_tri_act <= w_tri;
        end
    end
`endif

    assign o_ramp = r_ramp;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_ramp_gen.sv
// Bench for ramp_gen: DIV=1 and DIV=4 instances on shared inputs,
// directed sequences then random stimulus against an arithmetic model.
module tb_ramp_gen;
    import ramp_gen_pkg::*;

    localparam int W = 16;
`ifdef RAMP_GEN_TRIANGLE_EN
    localparam bit TRI_ON = 1'b1;
`else
    localparam bit TRI_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] step;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] ramp0;
    logic [W-1:0] ramp1;
    logic         wrap0;
    logic         wrap1;

    ramp_gen #(.WIDTH(W), .DIV(1)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode),
        .i_step(step), .i_lo(lo), .i_hi(hi),
        .o_ramp(ramp0), .o_wrap(wrap0)
    );

    ramp_gen #(.WIDTH(W), .DIV(4)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode),
        .i_step(step), .i_lo(lo), .i_hi(hi),
        .o_ramp(ramp1), .o_wrap(wrap1)
    );

    int n_vec = 0;
    int n_err = 0;

    int m_div  [2] = '{1, 4};
    int m_ramp [2];
    int m_wrap [2];
    int m_cnt  [2];
    bit m_dn   [2];
    bit m_tri  [2];

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic model_clk(input int k);
        int r, s, l, h;
        bit tick, trim;
        if (rst) begin
            m_ramp[k] = 0; m_wrap[k] = 0; m_cnt[k] = 0;
            m_dn[k] = 0;   m_tri[k] = 0;
            return;
        end
        m_wrap[k] = 0;
        if (!en) return;
        tick = (m_cnt[k] == m_div[k] - 1);
        m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
        if (!tick) return;
        r = m_ramp[k]; s = int'(step); l = int'(lo); h = int'(hi);
        trim = TRI_ON && (mode == MODE_TRI);
        if (trim && !m_tri[k]) m_dn[k] = 0;
        m_tri[k] = trim;
        if (l > h) r = l;
        else if (mode == MODE_HOLD || s == 0) r = r;
        else if (r < l || r > h) begin
            r = (mode == MODE_DN) ? h : l;
            m_dn[k] = 0;
        end else if (mode == MODE_DN) begin
            if (r < l + s) begin r = h; m_wrap[k] = 1; end
            else r = r - s;
        end else if (trim && m_dn[k]) begin
            if (r < l + s) begin r = l; m_wrap[k] = 1; m_dn[k] = 0; end
            else r = r - s;
        end else if (trim) begin
            if (r + s > h) begin r = h; m_dn[k] = 1; end
            else r = r + s;
        end else begin
            if (r + s > h) begin r = l; m_wrap[k] = 1; end
            else r = r + s;
        end
        m_ramp[k] = r;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clk(0);
        model_clk(1);
        @(negedge clk);
        check("ramp_div1", int'(ramp0), m_ramp[0]);
        check("wrap_div1", int'(wrap0), m_wrap[0]);
        check("ramp_div4", int'(ramp1), m_ramp[1]);
        check("wrap_div4", int'(wrap1), m_wrap[1]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    int t2_r [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int t3_r [5] = '{10, 6, 2, 10, 6};
    int t3_w [5] = '{0, 0, 0, 1, 0};
    int t4_r [3] = '{16'h8000, 0, 16'h8000};
    int t4_w [3] = '{0, 1, 0};
`ifdef RAMP_GEN_TRIANGLE_EN
    int t6_r [7] = '{3, 6, 7, 4, 1, 0, 3};
    int t6_w [7] = '{0, 0, 0, 0, 0, 1, 0};
`else
    int t6_r [4] = '{3, 6, 0, 3};
    int t6_w [4] = '{0, 0, 1, 0};
`endif

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_UP;
        step = '0; lo = '0; hi = '0;

        cycle();
        cycle();
        check("rst_ramp", int'(ramp0), 0);
        check("rst_wrap", int'(wrap0), 0);
        rst = 1'b0;
        repeat (3) cycle();
        check("idle_ramp", int'(ramp0), 0);

        en = 1'b1; mode = MODE_UP; step = 16'd1; lo = 16'd0; hi = 16'd3;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("saw_up_ramp", int'(ramp0), t2_r[i]);
            check("saw_up_wrap", int'(wrap0), int'(t2_r[i] == 0));
        end

        do_reset();
        mode = MODE_DN; step = 16'd4; lo = 16'd2; hi = 16'd10;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("saw_dn_ramp", int'(ramp0), t3_r[i]);
            check("saw_dn_wrap", int'(wrap0), t3_w[i]);
        end

        do_reset();
        mode = MODE_UP; step = 16'h8000; lo = 16'h0; hi = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("ovf_ramp", int'(ramp0), t4_r[i]);
            check("ovf_wrap", int'(wrap0), t4_w[i]);
        end

        do_reset();
        mode = MODE_UP; step = 16'd1; lo = 16'd0; hi = 16'd100;
        repeat (4) cycle();
        check("div4_first", int'(ramp1), 1);
        repeat (2) cycle();
        en = 1'b0;
        repeat (3) cycle();
        en = 1'b1;
        cycle();
        check("div4_paused", int'(ramp1), 1);
        cycle();
        check("div4_resume", int'(ramp1), 2);

        do_reset();
        mode = MODE_TRI; step = 16'd3; lo = 16'd0; hi = 16'd7;
        foreach (t6_r[i]) begin
            cycle();
            check("tri_ramp", int'(ramp0), t6_r[i]);
            check("tri_wrap", int'(wrap0), t6_w[i]);
        end

        mode = MODE_HOLD;
        cycle();
        check("hold_ramp", int'(ramp0), t6_r[$size(t6_r)-1]);
        mode = MODE_UP; lo = 16'd9; hi = 16'd4;
        cycle();
        check("bad_lim_ramp", int'(ramp0), 9);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    lo   = 16'($urandom);
                    hi   = 16'($urandom);
                    step = 16'($urandom);
                end else begin
                    lo   = 16'($urandom_range(0, 30));
                    hi   = 16'($urandom_range(10, 60));
                    step = 16'($urandom_range(0, 9));
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
